// File: rtl/stream_demux_1to4_pkg.sv
// Shared types and constants for the 1-to-4 stream demultiplexer.
package stream_demux_1to4_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned DATA_W = 32;

  typedef logic [SEL_W-1:0] ch_idx_t;

  // One-hot decode of a channel index.
  function automatic logic [NUM_CH-1:0] ch_onehot(input ch_idx_t idx);
    return NUM_CH'(1) << idx;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry channel buffer: loads a word, holds it until the consumer takes it.
// A load in the same cycle as a drain replaces the word and keeps valid set.
module demux_slot #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] load_data,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_valid
);

  logic [N-1:0] data_q, data_d;
  logic         valid_q, valid_d;
  logic         drain;

  // Next-state: drain clears, load sets and captures (load wins).
  always_comb begin
    drain   = valid_q & out_ready;
    valid_d = valid_q;
    data_d  = data_q;
    if (drain) begin
      valid_d = 1'b0;
    end
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end
  end

  // Buffer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;

endmodule

// File: rtl/stream_demux_1to4.sv
// Registered 1-to-4 stream demultiplexer with a one-entry buffer per channel.
// Optional build macro: DEMUX_AUTO_SEQ_EN -- destination taken from a
// round-robin counter that advances per accepted word; in_sel is ignored.
module stream_demux_1to4
  import stream_demux_1to4_pkg::*;
#(
  parameter int unsigned N = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     in_data,
  input  logic [SEL_W-1:0] in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N-1:0]     out0_data,
  output logic [N-1:0]     out1_data,
  output logic [N-1:0]     out2_data,
  output logic [N-1:0]     out3_data,
  output logic             out0_valid,
  output logic             out1_valid,
  output logic             out2_valid,
  output logic             out3_valid,
  input  logic             out0_ready,
  input  logic             out1_ready,
  input  logic             out2_ready,
  input  logic             out3_ready,
  output logic             busy
);

  ch_idx_t             dest;
  logic                accept;
  logic [NUM_CH-1:0]   slot_valid;
  logic [NUM_CH-1:0]   slot_ready;
  logic [NUM_CH-1:0]   slot_load;
  logic [N-1:0]        slot_data [NUM_CH];

  assign slot_ready = {out3_ready, out2_ready, out1_ready, out0_ready};

`ifdef DEMUX_AUTO_SEQ_EN
  ch_idx_t seq_q, seq_d;
  logic    unused_sel;

  assign unused_sel = ^in_sel;

  // Sequence counter advances only on an accepted word, wrapping 3 -> 0.
  always_comb begin
    seq_d = seq_q;
    if (accept) begin
      seq_d = seq_q + SEL_W'(1);
    end
  end

  // Sequence counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      seq_q <= '0;
    end else begin
      seq_q <= seq_d;
    end
  end

  assign dest = seq_q;
`else
  assign dest = in_sel;
`endif

  // Selected channel can take a word if empty or draining this cycle.
  assign in_ready  = ~slot_valid[dest] | slot_ready[dest];
  assign accept    = in_valid & in_ready;
  assign slot_load = accept ? ch_onehot(dest) : '0;

  // Four independent channel buffers.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    demux_slot #(.N(N)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (slot_load[k]),
      .load_data (in_data),
      .out_ready (slot_ready[k]),
      .out_data  (slot_data[k]),
      .out_valid (slot_valid[k])
    );
  end

  assign out0_data  = slot_data[0];
  assign out1_data  = slot_data[1];
  assign out2_data  = slot_data[2];
  assign out3_data  = slot_data[3];
  assign out0_valid = slot_valid[0];
  assign out1_valid = slot_valid[1];
  assign out2_valid = slot_valid[2];
  assign out3_valid = slot_valid[3];

  // Derived purely from the valid flops.
  assign busy = |slot_valid;

endmodule
